// File: rtl/vl_stim_sweeper.sv
// vl_stim_sweeper: clocked exhaustive {0,1,X,Z} stimulus engine for gate-equivalence systests.
// Latency: each vector costs SETTLE drive cycles + 1 check cycle; done after 4^NIN*(SETTLE+1) cycles.
// Backpressure: none; start is ignored while busy. Optional macro VL_STIM_STOP_ON_FAIL_EN halts on first failure.
`timescale 1ns/1ps
module vl_stim_sweeper #(
    parameter int NIN    = 3,
    parameter int SETTLE = 4,
    parameter int CW     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [NIN-1:0]   src,
    output logic             check,
    input  logic             mismatch,
    output logic             busy,
    output logic             done,
    output logic [2*NIN-1:0] vec_idx,
    output logic [CW-1:0]    err_count,
    output logic             first_fail_valid,
    output logic [2*NIN-1:0] first_fail_idx
);
    localparam int VW = 2 * NIN;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [SW-1:0] settle_cnt;
    logic          settle_end;
    logic          vec_fail;
    logic          vec_last;
    logic          sweep_end;
    logic          sweep_go;
    logic          vec_adv;

    // Each stimulus bit is a pure decode of its base-4 digit, so src is valid in the first DRIVE cycle.
    for (genvar i = 0; i < NIN; i++) begin : g_src
        assign src[i] = (vec_idx[2*i+1:2*i] == 2'd3) ? 1'bz :
                        (vec_idx[2*i+1:2*i] == 2'd2) ? 1'bx :
                        vec_idx[2*i];
    end

    assign settle_end = (settle_cnt == SW'(SETTLE - 1));
    // Anything but a clean 0 from the compare stage (1, X or Z) is a failure.
    assign vec_fail   = (mismatch !== 1'b0);
    assign vec_last   = (vec_idx == {VW{1'b1}});

`ifdef VL_STIM_STOP_ON_FAIL_EN
    assign sweep_end = vec_last || vec_fail;
`else
    assign sweep_end = vec_last;
`endif

    always_comb begin
        state_d  = state_q;
        check    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        sweep_go = 1'b0;
        vec_adv  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = DRIVE;
                    sweep_go = 1'b1;
                end
            end
            DRIVE: begin
                busy = 1'b1;
                if (settle_end) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                busy  = 1'b1;
                check = 1'b1;
                if (sweep_end) begin
                    state_d = DONE;
                end else begin
                    state_d = DRIVE;
                    vec_adv = 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d  = DRIVE;
                    sweep_go = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRIVE is only ever entered from another state, so a counter cleared outside DRIVE restarts on entry.
    always_ff @(posedge clk) begin
        if (reset || state_q != DRIVE) begin
            settle_cnt <= '0;
        end else if (settle_end) begin
            settle_cnt <= '0;
        end else begin
            settle_cnt <= settle_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vec_idx          <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else if (sweep_go) begin
            vec_idx          <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else if (state_q == CHECK) begin
            if (vec_fail) begin
                if (err_count != {CW{1'b1}}) begin
                    err_count <= err_count + CW'(1);
                end
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_idx   <= vec_idx;
                end
            end
            if (vec_adv) begin
                vec_idx <= vec_idx + VW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vl_stim_sweeper.sv
// Bench for vl_stim_sweeper (NIN=2, SETTLE=2): directed sweeps with randomized mismatch patterns,
// checked every cycle against a schedule/arithmetic model of the sweep.
`timescale 1ns/1ps
module tb_vl_stim_sweeper;
    localparam int NIN    = 2;
    localparam int SETTLE = 2;
    localparam int CW     = 16;
    localparam int CWS    = 3;
    localparam int NVEC   = 16;
    localparam int PER    = SETTLE + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           mismatch;

    wire  [NIN-1:0] src;
    logic           check, busy, done, ffv;
    logic [3:0]     vec_idx, ffi;
    logic [CW-1:0]  err_count;

    wire  [NIN-1:0] src_s;
    logic           check_s, busy_s, done_s, ffv_s;
    logic [3:0]     vec_idx_s, ffi_s;
    logic [CWS-1:0] err_count_s;

    int   n_vec = 0;
    int   n_err = 0;
    bit   four_state;
    logic probe;
    logic pat [NVEC];

    vl_stim_sweeper #(.NIN(NIN), .SETTLE(SETTLE), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .src(src), .check(check),
        .mismatch(mismatch), .busy(busy), .done(done), .vec_idx(vec_idx),
        .err_count(err_count), .first_fail_valid(ffv), .first_fail_idx(ffi)
    );

    vl_stim_sweeper #(.NIN(NIN), .SETTLE(SETTLE), .CW(CWS)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .src(src_s), .check(check_s),
        .mismatch(mismatch), .busy(busy_s), .done(done_s), .vec_idx(vec_idx_s),
        .err_count(err_count_s), .first_fail_valid(ffv_s), .first_fail_idx(ffi_s)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: observed no end of test, required end within 5000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NIN-1:0] decode(input int k);
        logic [NIN-1:0] v;
        int d;
        for (int i = 0; i < NIN; i++) begin
            d = (k >> (2 * i)) % 4;
            if (d == 0)      v[i] = 1'b0;
            else if (d == 1) v[i] = 1'b1;
            else if (d == 2) v[i] = 1'bx;
            else             v[i] = 1'bz;
        end
        return v;
    endfunction

    // X/Z digits are only checked bit-exactly on a 4-state simulator.
    task automatic chk_src(input logic [NIN-1:0] obs, input int k);
        logic [NIN-1:0] exp;
        bit ok;
        int d;
        exp = decode(k);
        ok  = 1'b1;
        for (int i = 0; i < NIN; i++) begin
            d = (k >> (2 * i)) % 4;
            if ((d < 2 || four_state) && obs[i] !== exp[i]) ok = 1'b0;
        end
        n_vec++;
        assert (ok) else begin
            n_err++;
            $error("FAIL src: observed %b, expected %b", obs, exp);
        end
    endtask

    function automatic logic rnd4();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0)      return 1'b0;
        else if (r == 1) return 1'b1;
        else if (r == 2) return 1'bx;
        else             return 1'bz;
    endfunction

    function automatic int count_before(input int n);
        int c = 0;
        for (int j = 0; j < n; j++) if (pat[j] !== 1'b0) c++;
        return c;
    endfunction

    function automatic int first_fail();
        for (int j = 0; j < NVEC; j++) if (pat[j] !== 1'b0) return j;
        return -1;
    endfunction

    // nclosed = number of vectors whose check cycle has already completed.
    task automatic check_outputs(input int k, input bit e_chk, input bit e_busy,
                                 input bit e_done, input int nclosed);
        int cnt, ff;
        bit fv;
        cnt = count_before(nclosed);
        ff  = first_fail();
        fv  = (ff >= 0) && (ff < nclosed);
        chk("check", 32'(check), 32'(e_chk));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("vec_idx", 32'(vec_idx), k);
        chk_src(src, k);
        chk("err_count", 32'(err_count), (cnt > 65535) ? 65535 : cnt);
        chk("err_count_sat", 32'(err_count_s), (cnt > 7) ? 7 : cnt);
        chk("first_fail_valid", 32'(ffv), 32'(fv));
        chk("first_fail_idx", 32'(ffi), fv ? ff : 0);
        chk("done_sat", 32'(done_s), 32'(e_done));
    endtask

    task automatic run_sweep(input bit junk, input int busy_start_vec,
                             input int reset_vec, input bit hold);
        int ff, last, ncyc, k, ph;
        ff   = first_fail();
        last = NVEC - 1;
`ifdef VL_STIM_STOP_ON_FAIL_EN
        if (ff >= 0) last = ff;
`endif
        ncyc     = (last + 1) * PER;
        start    = 1'b1;
        mismatch = junk ? rnd4() : 1'b0;
        for (int t = 1; t <= ncyc; t++) begin
            @(negedge clk);
            k  = (t - 1) / PER;
            ph = (t - 1) % PER;
            check_outputs(k, ph == PER - 1, 1'b1, 1'b0, k);
            if (k == reset_vec) begin
                reset = 1'b1;
                start = 1'b0;
                @(negedge clk);
                check_outputs(0, 1'b0, 1'b0, 1'b0, 0);
                reset = 1'b0;
                repeat (4) begin
                    mismatch = junk ? rnd4() : 1'b0;
                    @(negedge clk);
                    check_outputs(0, 1'b0, 1'b0, 1'b0, 0);
                end
                return;
            end
            start    = hold || (k == busy_start_vec);
            mismatch = (ph == PER - 1) ? pat[k] : (junk ? rnd4() : 1'b0);
        end
        @(negedge clk);
        check_outputs(last, 1'b0, 1'b0, 1'b1, last + 1);
        if (hold) begin
            @(negedge clk);
            check_outputs(0, 1'b0, 1'b1, 1'b0, 0);
            start = 1'b0;
        end else begin
            repeat (2) begin
                mismatch = junk ? rnd4() : 1'b0;
                @(negedge clk);
                check_outputs(last, 1'b0, 1'b0, 1'b1, last + 1);
            end
        end
    endtask

    initial begin
        probe      = 1'bx;
        four_state = $isunknown(probe);
        reset      = 1'b1;
        start      = 1'b0;
        mismatch   = 1'b0;
        for (int j = 0; j < NVEC; j++) pat[j] = 1'b0;

        // Reset state, and reset overriding start.
        repeat (3) @(negedge clk);
        check_outputs(0, 1'b0, 1'b0, 1'b0, 0);
        start = 1'b1;
        @(negedge clk);
        check_outputs(0, 1'b0, 1'b0, 1'b0, 0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_outputs(0, 1'b0, 1'b0, 1'b0, 0);

        // Clean sweep, mismatch tied low.
        run_sweep(1'b0, -1, -1, 1'b0);

        // Single failure at vector 5.
        pat[5] = 1'b1;
        run_sweep(1'b0, -1, -1, 1'b0);

        // X on every vector, then 1 on every vector (saturation in the narrow counter).
        for (int j = 0; j < NVEC; j++) pat[j] = 1'bx;
        run_sweep(1'b1, -1, -1, 1'b0);
        for (int j = 0; j < NVEC; j++) pat[j] = 1'b1;
        run_sweep(1'b1, -1, -1, 1'b0);

        // Single failure at vector 3.
        for (int j = 0; j < NVEC; j++) pat[j] = 1'b0;
        pat[3] = 1'b1;
        run_sweep(1'b0, -1, -1, 1'b0);

        // Random sparse failures with a start pulse while busy at vector 7.
        for (int j = 0; j < NVEC; j++) pat[j] = ($urandom_range(0, 2) == 0) ? rnd4() : 1'b0;
        run_sweep(1'b1, 7, -1, 1'b0);

        // Random failures with start held high: immediate restart after one done cycle.
        for (int j = 0; j < NVEC; j++) pat[j] = ($urandom_range(0, 2) == 0) ? rnd4() : 1'b0;
        run_sweep(1'b1, -1, -1, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_outputs(0, 1'b0, 1'b0, 1'b0, 0);
        reset = 1'b0;
        @(negedge clk);
        check_outputs(0, 1'b0, 1'b0, 1'b0, 0);

        // Reset in the middle of a sweep at vector 9.
        for (int j = 0; j < NVEC; j++) pat[j] = 1'b0;
        run_sweep(1'b1, -1, 9, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
